alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Execute-stage arithmetic block of the single-cycle MIPS datapath. It combines three functions. It decodes the 2-bit main-control ALU opcode plus the R-type funct field into a 4-bit ALU control code. It performs the selected 32-bit ALU operation into a registered result with a zero flag used for branch decisions. It also computes the PC+4 and branch-target addresses.

## Interface
Parameters:
- WIDTH, 32, datapath width for operands, result and PC values.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- alu_op  in  2  ALU opcode from main control.
- funct  in  6  instruction[5:0].
- a  in  WIDTH  operand A (register read data 1).
- b  in  WIDTH  operand B (register read data 2 or sign-extended immediate, already muxed).
- pc  in  WIDTH  current program counter.
- imm_ext  in  WIDTH  sign-extended 16-bit immediate.
- alu_ctrl  out  4  decoded ALU control code.
- alu_result  out  WIDTH  registered ALU result.
- zero  out  1  registered; 1 when the registered alu_result is all zeros.
- overflow  out  1  registered signed overflow flag.
- pc_plus4  out  WIDTH  pc + 4.
- branch_target  out  WIDTH  pc_plus4 + (imm_ext << 2).

## Operation
alu_ctrl decode (combinational):
- alu_op 00 → 0010 (add; lw/sw address).
- alu_op 01 → 0110 (sub; beq compare).
- alu_op 11 → 0001 (or; ori-class immediates).
- alu_op 10 selects by funct:
  - 100000 → 0010 add.
  - 100010 → 0110 sub.
  - 100100 → 0000 and.
  - 100101 → 0001 or.
  - 101010 → 0111 slt.
  - 100111 → 1100 nor.
  - any other funct → 1111 invalid.

ALU function by alu_ctrl:
- 0000 → a & b.
- 0001 → a | b.
- 0010 → a + b, modulo 2^WIDTH.
- 0110 → a − b, modulo 2^WIDTH.
- 0111 → 1 if signed(a) < signed(b), else 0. Uses a true signed compare, not the sign bit of the difference, so it is correct on overflow.
- 1100 → ~(a | b).
- 1111 or any unlisted code → result 0.

Flags:
- overflow is 1 only for add/sub when the operand signs and the result sign indicate two's-complement overflow; it is 0 for every other operation.
- zero is derived from the same value that is loaded into alu_result.

Address adders (combinational, wrap modulo 2^WIDTH, no carry out):
- pc_plus4 = pc + 4.
- branch_target = pc_plus4 + {imm_ext[WIDTH-3:0], 2'b00}. Negative immediates produce backward targets.

## Timing
- alu_ctrl, pc_plus4 and branch_target are purely combinational and valid in the same cycle as their inputs.
- alu_result, zero and overflow have 1-cycle latency: they are captured at the rising clk edge from the a, b, alu_op and funct values present just before that edge.
- No handshake. A new operation is accepted every cycle and outputs hold between edges.
- rst low forces the registered outputs immediately, independent of clk: alu_result = 0, zero = 1, overflow = 0. These values hold while rst is low.
- Asserting rst mid-operation discards the pending result. After rst rises, the first rising edge captures the current inputs.
- Combinational outputs are not affected by rst.
- Input changes between edges do not disturb the registered outputs.

## Test plan
- Reset: drive rst low with a = 5, b = 3, alu_op = 00, then toggle clk → alu_result 0, zero 1, overflow 0. Release rst; after the next edge → alu_result 8, zero 0.
- Decode sweep: alu_op 10 with funct 100000/100010/100100/100101/101010/100111/000000 → alu_ctrl 0010/0110/0000/0001/0111/1100/1111. alu_op 00/01/11 → 0010/0110/0001 regardless of funct.
- Arithmetic and flags:
  - a = 0x7FFFFFFF, b = 1, add → result 0x80000000, overflow 1.
  - a = 7, b = 7, sub (alu_op 01) → result 0, zero 1.
  - a = 0x00FF00FF, b = 0x0F0F0F0F: and → 0x000F000F; or → 0x0FFF0FFF; nor → 0xF000F000.
- SLT signed: a = 0xFFFFFFFF (−1), b = 1 → 1. a = 0x80000000, b = 0x7FFFFFFF → 1. a = 1, b = 0xFFFFFFFF → 0. Invalid funct → result 0, zero 1.
- Address adders:
  - pc = 0x00000000 → pc_plus4 0x00000004.
  - pc = 0x00000100, imm_ext = 0xFFFFFFFE → branch_target 0x000000FC.
  - pc = 0xFFFFFFFC → pc_plus4 0x00000000 (wrap).
- Latency check: change a/b every cycle → each alu_result equals the operation on the operands from the previous edge, with no skipped or repeated values.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage arithmetic block for the single-cycle MIPS datapath.
// Decodes ALU control from the main-control opcode and funct field, performs
// the selected operation into registered result/zero/overflow flags, and
// computes the sequential (pc + 4) and branch-target addresses.

package alu_exec_pkg;

    // Main-control ALU opcode as produced by the instruction decoder.
    typedef enum logic [1:0] {
        OP_MEM   = 2'b00,   // lw/sw address add
        OP_BRANCH = 2'b01,  // beq compare via subtract
        OP_RTYPE = 2'b10,   // operation selected by funct
        OP_IMM_OR = 2'b11   // ori-class immediates
    } alu_op_e;

    // Decoded ALU control code driving the datapath.
    typedef enum logic [3:0] {
        CTRL_AND = 4'b0000,
        CTRL_OR  = 4'b0001,
        CTRL_ADD = 4'b0010,
        CTRL_SUB = 4'b0110,
        CTRL_SLT = 4'b0111,
        CTRL_NOR = 4'b1100,
        CTRL_INV = 4'b1111
    } alu_ctrl_e;

    // R-type funct encodings recognised by the decoder.
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm_ext,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             overflow,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target
);

    alu_ctrl_e        ctrl_c;
    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] diff_c;
    logic             add_ovf_c;
    logic             sub_ovf_c;
    logic             slt_c;
    logic [WIDTH-1:0] next_result;
    logic             next_overflow;

    // Decode the main-control opcode and funct field into an ALU control code.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case statements can leave it unassigned (latch).
        ctrl_c = CTRL_INV;
        unique case (alu_op_e'(alu_op))
            OP_MEM:    ctrl_c = CTRL_ADD;
            OP_BRANCH: ctrl_c = CTRL_SUB;
            OP_IMM_OR: ctrl_c = CTRL_OR;
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl_c = CTRL_ADD;
                    FUNCT_SUB: ctrl_c = CTRL_SUB;
                    FUNCT_AND: ctrl_c = CTRL_AND;
                    FUNCT_OR:  ctrl_c = CTRL_OR;
                    FUNCT_SLT: ctrl_c = CTRL_SLT;
                    FUNCT_NOR: ctrl_c = CTRL_NOR;
                    default:   ctrl_c = CTRL_INV;
                endcase
            end
            default: ctrl_c = CTRL_INV;
        endcase
    end

    assign alu_ctrl = ctrl_c;

    // Adder/subtractor and signed compare shared by the result mux.
    always_comb begin
        sum_c  = a + b;
        diff_c = a - b;
        // Overflow when like-signed operands yield an opposite-signed sum.
        add_ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
        // Subtract overflows when operand signs differ and the sign of a flips.
        sub_ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
        // True signed compare, independent of the subtract's overflow.
        slt_c = $signed(a) < $signed(b);
    end

    // Select the operation result and its overflow flag for the next edge.
    always_comb begin
        next_result   = '0;
        next_overflow = 1'b0;
        case (ctrl_c)
            CTRL_AND: next_result = a & b;
            CTRL_OR:  next_result = a | b;
            CTRL_ADD: begin
                next_result   = sum_c;
                next_overflow = add_ovf_c;
            end
            CTRL_SUB: begin
                next_result   = diff_c;
                next_overflow = sub_ovf_c;
            end
            CTRL_SLT: next_result = {{(WIDTH-1){1'b0}}, slt_c};
            CTRL_NOR: next_result = ~(a | b);
            default: begin
                next_result   = '0;
                next_overflow = 1'b0;
            end
        endcase
    end

    // Capture result and flags each cycle; reset forces the idle values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: non-blocking assignments in clocked blocks so every
            // register samples pre-edge values regardless of statement order.
            alu_result <= '0;
            zero       <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            alu_result <= next_result;
            zero       <= (next_result == '0);
            overflow   <= next_overflow;
        end
    end

    // Sequential and branch-target addresses; both wrap with no carry out.
    assign pc_plus4      = pc + WIDTH'(4);
    assign branch_target = pc_plus4 + (imm_ext << 2);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed corner cases from the
// block's behaviour plus randomized operations compared against a
// behavioural model built on wide signed arithmetic.

module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm_ext;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic        overflow;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_result = 32'h0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_op        (alu_op),
        .funct         (funct),
        .a             (a),
        .b             (b),
        .pc            (pc),
        .imm_ext       (imm_ext),
        .alu_ctrl      (alu_ctrl),
        .alu_result    (alu_result),
        .zero          (zero),
        .overflow      (overflow),
        .pc_plus4      (pc_plus4),
        .branch_target (branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected control code straight from the opcode/funct table.
    function automatic logic [3:0] model_ctrl(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'b00) return 4'b0010;
        if (op == 2'b01) return 4'b0110;
        if (op == 2'b11) return 4'b0001;
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b100111: return 4'b1100;
            default:   return 4'b1111;
        endcase
    endfunction

    // Result and overflow computed with 64-bit signed arithmetic: overflow
    // is simply "the exact value does not fit in 32-bit two's complement".
    task automatic model_alu(input logic [3:0] c, input logic [31:0] av, input logic [31:0] bv,
                             output logic [31:0] r, output logic ov);
        longint sa;
        longint sb;
        longint s;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        s  = 0;
        r  = 32'h0;
        ov = 1'b0;
        case (c)
            4'b0010: s = sa + sb;
            4'b0110: s = sa - sb;
            default: s = 0;
        endcase
        case (c)
            4'b0000: r = av & bv;
            4'b0001: r = av | bv;
            4'b0010, 4'b0110: begin
                r  = 32'(s);
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b1100: r = ~(av | bv);
            default: r = 32'h0;
        endcase
    endtask

    // Apply one operation at the falling edge, check the decode and that the
    // registered outputs still hold, then check the capture after the edge.
    task automatic do_op(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] av, input logic [31:0] bv);
        logic [3:0]  c;
        logic [31:0] r;
        logic        ov;
        @(negedge clk);
        alu_op = op;
        funct  = f;
        a      = av;
        b      = bv;
        #1;
        check("hold_result", alu_result, exp_result);
        c = model_ctrl(op, f);
        check("alu_ctrl", {28'h0, alu_ctrl}, {28'h0, c});
        model_alu(c, av, bv, r, ov);
        @(posedge clk);
        #1;
        check("alu_result", alu_result, r);
        check("zero", {31'h0, zero}, {31'h0, (r == 32'h0)});
        check("overflow", {31'h0, overflow}, {31'h0, ov});
        exp_result = r;
    endtask

    // Combinational address adders, modelled with wide signed arithmetic.
    task automatic addr_chk(input logic [31:0] pcv, input logic [31:0] immv);
        longint p4;
        longint bt;
        pc      = pcv;
        imm_ext = immv;
        #1;
        p4 = longint'({32'h0, pcv}) + 4;
        bt = p4 + 4 * longint'($signed(immv));
        check("pc_plus4", pc_plus4, 32'(p4));
        check("branch_target", branch_target, 32'(bt));
    endtask

    logic [5:0] functs [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b101010, 6'b100111, 6'b000000};
    logic [31:0] corners [6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                                 32'h80000000, 32'h00000007};

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        rst     = 1'b0;
        alu_op  = 2'b00;
        funct   = 6'b0;
        a       = 32'd5;
        b       = 32'd3;
        pc      = 32'h0;
        imm_ext = 32'h0;

        // Reset holds the registered outputs through clock edges.
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", alu_result, 32'h0);
        check("rst_zero", {31'h0, zero}, 32'h1);
        check("rst_overflow", {31'h0, overflow}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_result", alu_result, 32'd8);
        check("post_rst_zero", {31'h0, zero}, 32'h0);
        exp_result = 32'd8;

        // Decode sweep, R-type and fixed opcodes.
        for (int i = 0; i < 7; i++) do_op(2'b10, functs[i], 32'h00FF00FF, 32'h0F0F0F0F);
        do_op(2'b00, 6'b101010, 32'd10, 32'd20);
        do_op(2'b01, 6'b100100, 32'd10, 32'd20);
        do_op(2'b11, 6'b100010, 32'h12340000, 32'h00005678);

        // Arithmetic and flag corners.
        do_op(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1);
        do_op(2'b01, 6'b000000, 32'd7, 32'd7);
        do_op(2'b01, 6'b000000, 32'h80000000, 32'h1);
        do_op(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1);
        do_op(2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF);
        do_op(2'b10, 6'b101010, 32'h1, 32'hFFFFFFFF);
        do_op(2'b10, 6'b111111, 32'hDEADBEEF, 32'h1);

        // Address adders, including a backward target and wrap.
        addr_chk(32'h00000000, 32'h00000000);
        addr_chk(32'h00000100, 32'hFFFFFFFE);
        addr_chk(32'hFFFFFFFC, 32'h00000003);
        for (int i = 0; i < 20; i++) addr_chk($urandom, $urandom);

        // Reset asserted between edges clears immediately and drops the pending op.
        do_op(2'b00, 6'b0, 32'd100, 32'd23);
        @(negedge clk);
        a = 32'h7FFFFFFF;
        b = 32'h1;
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_result", alu_result, 32'h0);
        check("async_rst_zero", {31'h0, zero}, 32'h1);
        check("async_rst_overflow", {31'h0, overflow}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_held_result", alu_result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_result", alu_result, 32'h80000000);
        check("rst_release_overflow", {31'h0, overflow}, 32'h1);
        exp_result = 32'h80000000;

        // Randomized back-to-back operations; new operands every cycle.
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            logic [5:0] f;
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : functs[$urandom_range(0, 6)];
            do_op(op, f, pick_operand(), pick_operand());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
